// File: rtl/matching_pursuit_sequencer_if.sv
// Handshake bundle between the matching pursuit sequencer, the chip start/done
// interface and the correlation / residual-update datapaths.
interface matching_pursuit_sequencer_if #(
  parameter int N_ATOMS   = 64,
  parameter int M_SAMPLES = 32,
  parameter int DW        = 16,
  parameter int IW        = 4
);
  localparam int AW = $clog2(N_ATOMS);
  localparam int SW = $clog2(M_SAMPLES);

  logic                 start;
  logic [IW-1:0]        max_iter;
  logic                 busy;
  logic                 done;

  logic                 corr_en;
  logic [AW-1:0]        corr_atom;
  logic                 corr_valid;
  logic signed [DW-1:0] corr_value;

  logic                 upd_en;
  logic [SW-1:0]        upd_sample;
  logic [AW-1:0]        upd_atom;
  logic signed [DW-1:0] upd_coef;
  logic                 upd_ack;

  logic                 sel_valid;
  logic [AW-1:0]        sel_atom;
  logic signed [DW-1:0] sel_coef;
  logic [IW-1:0]        iter_count;

  modport master (
    input  start, max_iter, corr_valid, corr_value, upd_ack,
    output busy, done, corr_en, corr_atom, upd_en, upd_sample, upd_atom, upd_coef,
           sel_valid, sel_atom, sel_coef, iter_count
  );

  modport slave (
    output start, max_iter, corr_valid, corr_value, upd_ack,
    input  busy, done, corr_en, corr_atom, upd_en, upd_sample, upd_atom, upd_coef,
           sel_valid, sel_atom, sel_coef, iter_count
  );
endinterface

// File: rtl/matching_pursuit_sequencer.sv
// Iteration sequencer for the matching pursuit chip: correlation sweep, argmax,
// residual-update sweep, selection output. Optional early stop: MP_EARLY_STOP_EN.
module matching_pursuit_sequencer #(
  parameter int N_ATOMS   = 64,
  parameter int M_SAMPLES = 32,
  parameter int DW        = 16,
  parameter int IW        = 4,
  parameter int STOP_THR  = 256
) (
  input  logic clock,
  input  logic reset_n,
  matching_pursuit_sequencer_if.master bus
);
  localparam int AW = $clog2(N_ATOMS);
  localparam int SW = $clog2(M_SAMPLES);
  localparam logic [AW-1:0]        LAST_ATOM   = AW'(N_ATOMS - 1);
  localparam logic [SW-1:0]        LAST_SAMPLE = SW'(M_SAMPLES - 1);
  localparam logic [DW-1:0]        THR         = DW'(STOP_THR);
  localparam logic signed [DW-1:0] MOST_NEG    = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        MAX_POS     = {1'b0, {(DW-1){1'b1}}};
`ifdef MP_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CORR, S_SEL, S_UPD, S_NEXT, S_FIN} state_t;

  state_t               state, next_state;
  logic [IW-1:0]        k_reg;
  logic [IW-1:0]        iter_next;
  logic [DW-1:0]        corr_mag, best_mag;
  logic [AW-1:0]        best_atom;
  logic signed [DW-1:0] best_coef;
  logic                 accept, corr_beat, upd_beat, stop_now, take_sel;

  assign accept    = (state == S_IDLE) && bus.start;
  assign corr_beat = bus.corr_en && bus.corr_valid;
  assign upd_beat  = bus.upd_en && bus.upd_ack;
  assign iter_next = bus.iter_count + IW'(1);
  // The comparison is always built so STOP_THR stays referenced; it folds away when disabled.
  assign stop_now  = EARLY_STOP && (best_mag < THR);
  assign take_sel  = (state == S_SEL) && !stop_now;

  assign bus.busy    = state inside {S_CORR, S_SEL, S_UPD, S_NEXT};
  assign bus.done    = (state == S_FIN);
  assign bus.corr_en = (state == S_CORR);
  assign bus.upd_en  = (state == S_UPD);

  // The most negative code has no positive twin; it saturates to the largest magnitude.
  always_comb begin
    corr_mag = bus.corr_value;
    if (bus.corr_value == MOST_NEG)  corr_mag = MAX_POS;
    else if (bus.corr_value[DW-1])   corr_mag = DW'(-bus.corr_value);
  end

  always_comb begin
    // NOTE: next_state is defaulted first so no path through the case leaves it unassigned (no latch).
    next_state = state;
    case (state)
      S_IDLE: if (bus.start) next_state = (bus.max_iter == '0) ? S_FIN : S_CORR;
      S_CORR: if (corr_beat && bus.corr_atom == LAST_ATOM) next_state = S_SEL;
      S_SEL:  next_state = stop_now ? S_FIN : S_UPD;
      S_UPD:  if (upd_beat && bus.upd_sample == LAST_SAMPLE) next_state = S_NEXT;
      S_NEXT: next_state = (iter_next == k_reg) ? S_FIN : S_CORR;
      S_FIN:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: all state updates are non-blocking so every register sees pre-edge values.
      k_reg          <= '0;
      bus.iter_count <= '0;
      bus.corr_atom  <= '0;
      bus.upd_sample <= '0;
      bus.upd_atom   <= '0;
      bus.upd_coef   <= '0;
      bus.sel_valid  <= 1'b0;
      bus.sel_atom   <= '0;
      bus.sel_coef   <= '0;
      best_mag       <= '0;
      best_atom      <= '0;
      best_coef      <= '0;
    end else begin
      if (accept) begin
        k_reg          <= bus.max_iter;
        bus.iter_count <= '0;
      end
      if (state == S_NEXT) bus.iter_count <= iter_next;

      if (corr_beat)
        bus.corr_atom <= (bus.corr_atom == LAST_ATOM) ? '0 : bus.corr_atom + AW'(1);
      if (upd_beat)
        bus.upd_sample <= (bus.upd_sample == LAST_SAMPLE) ? '0 : bus.upd_sample + SW'(1);

      // Strict '>' keeps the lower index on ties; atom 0 always seeds the sweep.
      if (accept || state == S_NEXT) begin
        best_mag  <= '0;
        best_atom <= '0;
        best_coef <= '0;
      end else if (corr_beat && (bus.corr_atom == '0 || corr_mag > best_mag)) begin
        best_mag  <= corr_mag;
        best_atom <= bus.corr_atom;
        best_coef <= bus.corr_value;
      end

      bus.sel_valid <= take_sel;
      if (take_sel) begin
        bus.sel_atom <= best_atom;
        bus.sel_coef <= best_coef;
        bus.upd_atom <= best_atom;
        bus.upd_coef <= best_coef;
      end
    end
  end
endmodule
